store_buffer: RTL

Parametrised store buffer between the core's commit stage and the L1 D-cache store port. It accepts committed byte-masked stores, queues up to `DEPTH` entries and drains them in order to the D-cache with a `store_req`/`store_finished` handshake. It coalesces a new store into the youngest queued entry when both target the same word. It also provides combinational byte-level store-to-load forwarding for the load path.

---
 rtl/store_buffer_if.sv | 42 ++++
 rtl/store_buffer.sv | 119 +++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: commit-side store, D-cache store port, load-forwarding
// lookup and status signals of the store buffer, grouped as one bundle.
interface store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   localparam int MW = XLEN / 8;
   localparam int CW = $clog2(DEPTH + 1);
   logic              st_valid_i;
   logic              st_ready_o;
   logic [ADDR_W-1:0] st_addr_i;
   logic [XLEN-1:0]   st_data_i;
   logic [MW-1:0]     st_mask_i;
   logic              dc_store_req_o;
   logic [ADDR_W-1:0] dc_store_addr_o;
   logic [XLEN-1:0]   dc_store_data_o;
   logic [MW-1:0]     dc_store_mask_o;
   logic              dc_store_finished_i;
   logic              dc_store_miss_i;
   logic [ADDR_W-1:0] ld_addr_i;
   logic [MW-1:0]     ld_fwd_mask_o;
   logic [XLEN-1:0]   ld_fwd_data_o;
   logic              ld_fwd_hit_o;
   logic              ld_conflict_o;
   logic              empty_o;
   logic [CW-1:0]     count_o;
   modport slave (
      input  st_valid_i, st_addr_i, st_data_i, st_mask_i,
             dc_store_finished_i, dc_store_miss_i, ld_addr_i,
      output st_ready_o, dc_store_req_o, dc_store_addr_o, dc_store_data_o,
             dc_store_mask_o, ld_fwd_mask_o, ld_fwd_data_o, ld_fwd_hit_o,
             ld_conflict_o, empty_o, count_o
   );
   modport master (
      output st_valid_i, st_addr_i, st_data_i, st_mask_i,
             dc_store_finished_i, dc_store_miss_i, ld_addr_i,
      input  st_ready_o, dc_store_req_o, dc_store_addr_o, dc_store_data_o,
             dc_store_mask_o, ld_fwd_mask_o, ld_fwd_data_o, ld_fwd_hit_o,
             ld_conflict_o, empty_o, count_o
   );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order coalescing store queue draining to the D-cache,
// with byte-level store-to-load forwarding.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input logic clk_i,
   input logic rst_i,
   store_buffer_if.slave sb
);
   localparam int MW  = XLEN / 8;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int OFF = $clog2(MW);
   localparam int WW  = ADDR_W - OFF;
   typedef enum logic {IDLE, ISSUE} state_e;
   logic [WW-1:0]     word_q [DEPTH];
   logic [XLEN-1:0]   data_q [DEPTH];
   logic [MW-1:0]     mask_q [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d, young;
   logic [CW-1:0]     count_q, count_d;
   state_e            state_q, state_d;
   logic              dc_req_q, dc_req_d;
   logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
   logic [XLEN-1:0]   dc_data_q, dc_data_d;
   logic [MW-1:0]     dc_mask_q, dc_mask_d;
   logic [WW-1:0]     st_word, ld_word;
   logic [XLEN-1:0]   st_bits, merged, fwd_data;
   logic [MW-1:0]     fwd_mask;
   logic              full, co, push, alloc, pop, stage, head_co;
   assign st_word = sb.st_addr_i[ADDR_W-1:OFF];
   assign ld_word = sb.ld_addr_i[ADDR_W-1:OFF];
   assign young   = tail_q - PW'(1);
   assign full    = count_q == CW'(DEPTH);
   // The in-flight head is frozen: its payload is already on the D-cache port.
   assign co      = count_q != '0 && word_q[young] == st_word && !(state_q == ISSUE && young == head_q);
   assign push    = sb.st_valid_i && sb.st_ready_o;
   assign alloc   = push && !co;
   assign pop     = state_q == ISSUE && sb.dc_store_finished_i;
   assign merged  = (data_q[young] & ~st_bits) | (sb.st_data_i & st_bits);
   assign head_d  = pop ? head_q + PW'(1) : head_q;
   assign tail_d  = alloc ? tail_q + PW'(1) : tail_q;
   assign count_d = count_q + CW'(alloc) - CW'(pop);
   always_comb begin
      st_bits = '0;
      for (int b = 0; b < MW; b++) st_bits[8*b +: 8] = {8{sb.st_mask_i[b]}};
   end
   always_ff @(posedge clk_i) begin
      if (alloc) begin
         word_q[tail_q] <= st_word;
         data_q[tail_q] <= sb.st_data_i;
         mask_q[tail_q] <= sb.st_mask_i;
      end else if (push) begin
         data_q[young] <= merged;
         mask_q[young] <= mask_q[young] | sb.st_mask_i;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         dc_req_q  <= 1'b0;
         dc_addr_q <= '0;
         dc_data_q <= '0;
         dc_mask_q <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         dc_req_q  <= dc_req_d;
         dc_addr_q <= dc_addr_d;
         dc_data_q <= dc_data_d;
         dc_mask_q <= dc_mask_d;
      end
   end
   always_comb begin
      state_d = state_q == IDLE ? (count_q != '0 ? ISSUE : IDLE)
                                : (sb.dc_store_finished_i ? IDLE : ISSUE);
   end
   // Staging captures the head including any bytes coalesced into it this cycle.
   always_comb begin
      stage     = state_q == IDLE && count_q != '0;
      head_co   = push && co && young == head_q;
      dc_req_d  = stage ? 1'b1 : pop ? 1'b0 : dc_req_q;
      dc_addr_d = stage ? {word_q[head_q], {OFF{1'b0}}} : dc_addr_q;
      dc_data_d = stage ? (head_co ? merged : data_q[head_q]) : dc_data_q;
      dc_mask_d = stage ? (head_co ? mask_q[head_q] | sb.st_mask_i : mask_q[head_q]) : dc_mask_q;
   end
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      fwd_mask = '0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q && word_q[idx] == ld_word)
            for (int b = 0; b < MW; b++)
               if (mask_q[idx][b]) begin
                  fwd_mask[b]        = 1'b1;
                  fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
               end
      end
   end
   assign sb.st_ready_o      = !full || co;
   assign sb.dc_store_req_o  = dc_req_q;
   assign sb.dc_store_addr_o = dc_addr_q;
   assign sb.dc_store_data_o = dc_data_q;
   assign sb.dc_store_mask_o = dc_mask_q;
   assign sb.ld_fwd_mask_o   = fwd_mask;
   assign sb.ld_fwd_data_o   = fwd_data;
   assign sb.ld_fwd_hit_o    = &fwd_mask;
   assign sb.ld_conflict_o   = |fwd_mask && !(&fwd_mask);
   assign sb.empty_o         = count_q == '0 && state_q == IDLE;
   assign sb.count_o         = count_q;
endmodule
